// File: rtl/apb4_ram_slave.sv
// apb4_ram_slave: APB4 slave fronting a DEPTH x DATA_WIDTH register-file memory.
//   pclk    - clock; all state changes on its rising edge
//   prst    - asynchronous active-high reset (memory preloads mem[i] = i)
//   paddr   - byte address; word index = paddr >> log2(DATA_WIDTH/8)
//   psel    - slave select
//   penable - access phase
//   pwrite  - 1 = write, 0 = read
//   pwdata  - write data
//   pstrb   - write byte lanes
//   pprot   - protection type; only bit 0 (privileged) is used
//   pready  - transfer completion (low during inserted wait states)
//   prdata  - registered read data, held until the next read load
//   pslverr - error response, valid only on the completing access cycle
module apb4_ram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int PRIV_ONLY   = 0
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]      strb_q, strb_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;

  // Full-width index so out-of-range addresses are caught before truncation.
  logic [ADDR_WIDTH-1:0] idx;
  logic                  setup_err;
  logic                  unused_prot;

  assign idx         = paddr >> OFF;
  assign setup_err   = ({1'b0, idx} >= (ADDR_WIDTH + 1)'(DEPTH)) ||
                       ((PRIV_ONLY != 0) && !pprot[0]);
  assign unused_prot = ^pprot[2:1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          state_d = S_ACCESS;
          cnt_d   = CW'(WAIT_STATES);
          idx_d   = idx[IW-1:0];
          wr_d    = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          err_d   = setup_err;
          // Writes clear prdata; zero-wait reads load it here since the
          // setup edge is also the edge entering the final access cycle.
          if (pwrite)
            prdata_d = '0;
          else if (WAIT_STATES == 0)
            prdata_d = setup_err ? '0 : mem_q[idx[IW-1:0]];
        end
      end
      default: begin
        if (!psel) begin
          // Master abandoned the transfer: no write, no error.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1) && !wr_q)
            prdata_d = err_q ? '0 : mem_q[idx_q];
        end else if (penable) begin
          state_d = S_IDLE;
          mem_we  = wr_q && !err_q;
        end
      end
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  // Memory preloads with its own index so reads right after reset are known.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= DATA_WIDTH'(i);
    end else if (mem_we) begin
      for (int k = 0; k < BYTES; k++)
        if (strb_q[k])
          mem_q[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
    end
  end

  assign pready  = (state_q == S_IDLE) || (cnt_q == '0);
  assign prdata  = prdata_q;
  assign pslverr = (state_q == S_ACCESS) && (cnt_q == '0) && err_q;

endmodule

// File: doc/apb4_ram_slave.md
APB4_RAM_SLAVE -- requirements
Module: apb4_ram_slave

Interface -- parameters
REQ-001 SHALL provide parameters, one per line:
- ADDR_WIDTH, 32, paddr width in bits.
- DATA_WIDTH, 32, pwdata/prdata width; legal values 8, 16, 32, 64.
- DEPTH, 256, number of DATA_WIDTH-bit memory words.
- WAIT_STATES, 0, pready-low cycles inserted in each access phase; range 0..15.
- PRIV_ONLY, 0, when 1 only privileged accesses (pprot[0]=1) are accepted.

Interface -- ports (name, direction, width, meaning)
REQ-002 SHALL have one clock; reset is asynchronous and active-high. Ports:
- pclk, in, 1, clock; all state changes on its rising edge.
- prst, in, 1, asynchronous active-high reset.
- paddr, in, ADDR_WIDTH, byte address.
- psel, in, 1, slave select.
- penable, in, 1, access phase.
- pwrite, in, 1, 1 = write, 0 = read.
- pwdata, in, DATA_WIDTH, write data.
- pstrb, in, DATA_WIDTH/8, write byte lanes.
- pprot, in, 3, protection type; only bit 0 is used.
- pready, out, 1, transfer completion.
- prdata, out, DATA_WIDTH, read data.
- pslverr, out, 1, transfer error.

Function
REQ-003 SHALL use word index = paddr >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
REQ-004 SHALL flag a transfer as an error if the index is >= DEPTH, or if PRIV_ONLY=1 and pprot[0]=0.
REQ-005 SHALL implement two states:
- IDLE: setup phase (psel=1, penable=0) latches address, direction, data, strobes and error flag; loads the wait counter with WAIT_STATES; moves to ACCESS.
- ACCESS: counter nonzero and psel=1 -> decrement. Counter 0 with psel=1 and penable=1 -> complete and return to IDLE.
REQ-006 SHALL drive pready=1 in IDLE, pready=0 in ACCESS while the counter is nonzero, and pready=1 in ACCESS when the counter is 0 (combinational from state and counter).
REQ-007 SHALL complete each transfer in exactly 2+WAIT_STATES cycles (setup, waits, final access).
REQ-008 SHALL commit a write on the completion edge only, updating byte lane k only where pstrb[k]=1; pstrb=0 writes nothing and is not an error.
REQ-009 SHALL register prdata as mem[index] on the edge that enters the final access cycle: the setup edge when WAIT_STATES=0, otherwise the edge where the counter reaches 0.
REQ-010 SHALL hold prdata until the next read load.
REQ-011 SHALL load prdata with 0 for reads of an error address.
REQ-012 SHALL clear prdata to 0 at a write's setup edge.
REQ-013 SHALL ignore pstrb on reads.
REQ-014 SHALL drive pslverr = latched error flag only while in ACCESS with pready=1, and 0 at all other times.
REQ-015 SHALL block the memory update for an erroring write.
REQ-016 SHALL abort without a memory update or error if psel falls in ACCESS before completion, returning to IDLE next cycle.
REQ-017 SHALL ignore changes to paddr, pwrite, pwdata and pstrb after the setup edge for the rest of the transfer.
REQ-018 SHALL accept a setup phase in the cycle immediately after completion, giving back-to-back transfers.
REQ-019 SHALL size the wait counter at clog2(WAIT_STATES+1) bits, minimum 1.

Reset
REQ-020 SHALL, while prst=1 and regardless of pclk, force:
- state IDLE, wait counter 0;
- pready=1, prdata=0, pslverr=0;
- mem[i] = i truncated to DATA_WIDTH, for all i < DEPTH.
REQ-021 SHALL abandon any transfer in progress when prst asserts, with no memory write; the first setup after prst falls is serviced normally.

Verification
REQ-022 SHALL pass these directed scenarios:
- Reset, WAIT_STATES=0: read addr 0x10 -> prdata=0x4 in the access cycle, pready=1, pslverr=0, 2-cycle transfer.
- Write 0xAABBCCDD to 0x20 with pstrb=4'b0101, then read 0x20 -> 0x00BB00DD (initial word 0x8).
- WAIT_STATES=3: read 0x0C -> pready low 3 access cycles, then high with prdata=0x3; 5-cycle transfer.
- DEPTH=256: write to 0x400, then read 0x400 -> pslverr=1 on both completions; no memory change; read prdata=0.
- PRIV_ONLY=1: write with pprot=3'b000 -> pslverr=1, no write; same write with pprot=3'b001 -> pslverr=0, data stored.
- WAIT_STATES=2: prst pulsed mid-write, or psel dropped during waits -> target word unchanged, pready=1, next read correct.
